// File: rtl/lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// lcd_timing_gen
//
// Raster timing generator for the 800x480 RGB LCD panel.
//
// A horizontal/vertical counter pair walks the full raster, including sync
// and porches. From that position the block produces:
//   * pixel coordinate requests (pix_de/pix_x/pix_y) for the downstream
//     pattern/pixel generator,
//   * panel sync and data-enable (lcd_hs/lcd_vs/lcd_de), delayed by PIX_LAT
//     cycles so they line up with that generator's registered pixel output,
//   * the backlight enable (lcd_bl), which rises once the power-up delay ends.
//
// Control state machine:
//   STARTUP : counters held at 0, BL_DELAY-cycle power-up timer runs.
//   RUN     : counters free-run, frames are produced.
//   HALT    : counters held at 0, panel blank, backlight stays on.
// disp_en only takes effect on a frame boundary, so a frame is never truncated.
//
// Optional feature (macro LCD_TIMING_FRAME_CNT_EN):
//   Adds output frame_cnt[15:0], a wrapping count of frame_start pulses.
//   It updates in the cycle after each pulse and holds through HALT.
//
// Ports:
//   lcd_clk     in   pixel clock
//   sys_rst_n   in   asynchronous, active-low reset
//   disp_en     in   display enable, acted on at a frame boundary
//   pix_de      out  request: current raster position is active
//   pix_x       out  request column 0..H_VALID-1, else 0
//   pix_y       out  request row 0..V_VALID-1, else 0
//   frame_start out  one-cycle pulse on the first cycle of every frame (RUN)
//   lcd_hs      out  panel hsync, PIX_LAT-delayed
//   lcd_vs      out  panel vsync, PIX_LAT-delayed
//   lcd_de      out  panel DE, PIX_LAT-delayed copy of pix_de
//   lcd_bl      out  backlight enable
//   frame_cnt   out  frame counter (only with LCD_TIMING_FRAME_CNT_EN)
//
// PIX_LAT must be in 1..4.
// -----------------------------------------------------------------------------
module lcd_timing_gen #(
    parameter int H_SYNC   = 128,
    parameter int H_BACK   = 88,
    parameter int H_VALID  = 800,
    parameter int H_FRONT  = 40,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_VALID  = 480,
    parameter int V_FRONT  = 10,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIX_LAT  = 1,
    parameter int BL_DELAY = 1000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        disp_en,
    output logic        pix_de,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic        lcd_bl
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    // -------------------------------------------------------------------------
    // Raster geometry
    // -------------------------------------------------------------------------
    localparam int H_TOTAL   = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL   = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_ACT_BEG = H_SYNC + H_BACK;
    localparam int H_ACT_END = H_ACT_BEG + H_VALID;
    localparam int V_ACT_BEG = V_SYNC + V_BACK;
    localparam int V_ACT_END = V_ACT_BEG + V_VALID;

    localparam logic [10:0] H_LAST_C    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST_C    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_C    = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_BEG_C = 11'(H_ACT_BEG);
    localparam logic [10:0] H_ACT_END_C = 11'(H_ACT_END);
    localparam logic [10:0] V_ACT_BEG_C = 11'(V_ACT_BEG);
    localparam logic [10:0] V_ACT_END_C = 11'(V_ACT_END);

    // Active and idle levels of the syncs
    localparam logic HS_ACT  = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ACT  = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic HS_IDLE = ~HS_ACT;
    localparam logic VS_IDLE = ~VS_ACT;

    // Power-up timer counts 0..BL_DELAY-1 while in STARTUP
    localparam int                TMR_W    = (BL_DELAY > 1) ? $clog2(BL_DELAY) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(BL_DELAY - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  TMR_ZERO = TMR_W'(0);

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_RUN     = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t             state_r;
    state_t             state_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_s;
    logic [10:0]        h_cnt_r;
    logic [10:0]        v_cnt_r;
    logic [10:0]        h_cnt_s;
    logic [10:0]        v_cnt_s;

    logic               run_s;
    logic               h_act_s;
    logic               v_act_s;
    logic               de_s;
    logic [10:0]        x_s;
    logic [10:0]        y_s;
    logic               hs_s;
    logic               vs_s;
    logic               fs_s;
    logic               bl_s;

    logic               pix_de_r;
    logic [10:0]        pix_x_r;
    logic [10:0]        pix_y_r;
    logic               frame_start_r;
    logic               hs_raw_r;
    logic               vs_raw_r;
    logic               lcd_bl_r;

    logic [PIX_LAT-1:0] de_pipe_r;
    logic [PIX_LAT-1:0] hs_pipe_r;
    logic [PIX_LAT-1:0] vs_pipe_r;

    // Next state, power-up timer and next raster position
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        h_cnt_s = 11'd0;
        v_cnt_s = 11'd0;
        case (state_r)
            ST_STARTUP: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = TMR_ZERO;
                    if (disp_en) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_HALT;
                    end
                end else begin
                    timer_s = timer_r + TMR_ONE;
                end
            end
            ST_RUN: begin
                if (h_cnt_r == H_LAST_C) begin
                    h_cnt_s = 11'd0;
                    if (v_cnt_r == V_LAST_C) begin
                        // Last cycle of the frame: the only point where
                        // disp_en may stop the raster.
                        v_cnt_s = 11'd0;
                        if (disp_en) begin
                            state_s = ST_RUN;
                        end else begin
                            state_s = ST_HALT;
                        end
                    end else begin
                        v_cnt_s = v_cnt_r + 11'd1;
                    end
                end else begin
                    h_cnt_s = h_cnt_r + 11'd1;
                    v_cnt_s = v_cnt_r;
                end
            end
            ST_HALT: begin
                // Counters stay at 0, so re-entering RUN starts a fresh frame.
                if (disp_en) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_STARTUP;
                timer_s = TMR_ZERO;
            end
        endcase
    end

    // Region decode on the next position so the registered requests line up
    // with the counter registers they describe.
    always_comb begin
        run_s   = (state_s == ST_RUN);
        h_act_s = (h_cnt_s >= H_ACT_BEG_C) && (h_cnt_s < H_ACT_END_C);
        v_act_s = (v_cnt_s >= V_ACT_BEG_C) && (v_cnt_s < V_ACT_END_C);
        de_s    = run_s && h_act_s && v_act_s;
        if (de_s) begin
            x_s = h_cnt_s - H_ACT_BEG_C;
            y_s = v_cnt_s - V_ACT_BEG_C;
        end else begin
            x_s = 11'd0;
            y_s = 11'd0;
        end
        if (run_s && (h_cnt_s < H_SYNC_C)) begin
            hs_s = HS_ACT;
        end else begin
            hs_s = HS_IDLE;
        end
        if (run_s && (v_cnt_s < V_SYNC_C)) begin
            vs_s = VS_ACT;
        end else begin
            vs_s = VS_IDLE;
        end
        fs_s = run_s && (h_cnt_s == 11'd0) && (v_cnt_s == 11'd0);
        bl_s = (state_s != ST_STARTUP);
    end

    // State, timer and raster counter registers
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_STARTUP;
            timer_r <= TMR_ZERO;
            h_cnt_r <= 11'd0;
            v_cnt_r <= 11'd0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            h_cnt_r <= h_cnt_s;
            v_cnt_r <= v_cnt_s;
        end
    end

    // Registered pixel requests, raw syncs and backlight
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_de_r      <= 1'b0;
            pix_x_r       <= 11'd0;
            pix_y_r       <= 11'd0;
            frame_start_r <= 1'b0;
            hs_raw_r      <= HS_IDLE;
            vs_raw_r      <= VS_IDLE;
            lcd_bl_r      <= 1'b0;
        end else begin
            pix_de_r      <= de_s;
            pix_x_r       <= x_s;
            pix_y_r       <= y_s;
            frame_start_r <= fs_s;
            hs_raw_r      <= hs_s;
            vs_raw_r      <= vs_s;
            lcd_bl_r      <= bl_s;
        end
    end

    // Panel alignment chain; clocks in every state so HALT drains to idle
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_pipe_r <= {PIX_LAT{1'b0}};
            hs_pipe_r <= {PIX_LAT{HS_IDLE}};
            vs_pipe_r <= {PIX_LAT{VS_IDLE}};
        end else begin
            de_pipe_r[0] <= pix_de_r;
            hs_pipe_r[0] <= hs_raw_r;
            vs_pipe_r[0] <= vs_raw_r;
            for (int i = 1; i < PIX_LAT; i++) begin
                de_pipe_r[i] <= de_pipe_r[i-1];
                hs_pipe_r[i] <= hs_pipe_r[i-1];
                vs_pipe_r[i] <= vs_pipe_r[i-1];
            end
        end
    end

    assign pix_de      = pix_de_r;
    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign frame_start = frame_start_r;
    assign lcd_de      = de_pipe_r[PIX_LAT-1];
    assign lcd_hs      = hs_pipe_r[PIX_LAT-1];
    assign lcd_vs      = vs_pipe_r[PIX_LAT-1];
    assign lcd_bl      = lcd_bl_r;

`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter: bumps the cycle after each frame_start, wraps naturally
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_start_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_timing_gen.
//   dut_a : default 800x480 timing, PIX_LAT=1, BL_DELAY=1000.
//           Startup delay, first active line, vsync width, 1-cycle alignment.
//   dut_b : miniature raster (17x10 total, 8x4 active), PIX_LAT=3,
//           active-high syncs, BL_DELAY=5. Full frames, frame_start period,
//           HALT at frame boundary, resume, asynchronous reset mid-frame.
// -----------------------------------------------------------------------------
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a signals
    logic        a_rst_n, a_en;
    logic        a_de, a_fs, a_lhs, a_lvs, a_lde, a_bl;
    logic [10:0] a_x, a_y;
    // dut_b signals
    logic        b_rst_n, b_en;
    logic        b_de, b_fs, b_lhs, b_lvs, b_lde, b_bl;
    logic [10:0] b_x, b_y;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] a_fc, b_fc;
`endif

    lcd_timing_gen #(.PIX_LAT(1), .BL_DELAY(1000)) dut_a (
        .lcd_clk(clk), .sys_rst_n(a_rst_n), .disp_en(a_en),
        .pix_de(a_de), .pix_x(a_x), .pix_y(a_y), .frame_start(a_fs),
        .lcd_hs(a_lhs), .lcd_vs(a_lvs), .lcd_de(a_lde), .lcd_bl(a_bl)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    lcd_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_VALID(4), .V_FRONT(2),
        .HS_POL(1), .VS_POL(1), .PIX_LAT(3), .BL_DELAY(5)
    ) dut_b (
        .lcd_clk(clk), .sys_rst_n(b_rst_n), .disp_en(b_en),
        .pix_de(b_de), .pix_x(b_x), .pix_y(b_y), .frame_start(b_fs),
        .lcd_hs(b_lhs), .lcd_vs(b_lvs), .lcd_de(b_lde), .lcd_bl(b_bl)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected dut_b request/raw-sync values at RUN cycle k (k<0: idle)
    typedef struct packed {
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    function automatic exp_t exp_b(input int k);
        exp_t e;
        int   h, v;
        e = '0;
        if (k >= 0) begin
            h    = k % 17;
            v    = (k / 17) % 10;
            e.de = (h >= 7) && (h < 15) && (v >= 4) && (v < 8);
            if (e.de) begin
                e.x = 11'(h - 7);
                e.y = 11'(v - 4);
            end
            e.hs = (h < 4);
            e.vs = (v < 2);
            e.fs = (h == 0) && (v == 0);
        end
        return e;
    endfunction

    int kb, fs_prev, fc_exp, err_req, err_pan, err_fc;

    // Advance dut_b n cycles in RUN, checking requests and 3-cycle panel lag
    task automatic run_b(input int n);
        exp_t e, d;
        for (int i = 0; i < n; i++) begin
            tick;
            e = exp_b(kb);
            d = exp_b(kb - 3);
            if ({b_de, b_x, b_y, b_fs} !== {e.de, e.x, e.y, e.fs}) err_req++;
            if ({b_lde, b_lhs, b_lvs, b_bl} !== {d.de, d.hs, d.vs, 1'b1}) err_pan++;
`ifdef LCD_TIMING_FRAME_CNT_EN
            if (b_fc !== 16'(fc_exp)) err_fc++;
`endif
            if (e.fs) fc_exp++;
            if (b_fs === 1'b1) begin
                if (fs_prev >= 0) chk("b_fs_period", kb - fs_prev, 170);
                fs_prev = kb;
            end
            kb++;
        end
    endtask

    // dut_b power-up: 4 idle cycles after reset release
    task automatic startup_b;
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if ({b_bl, b_fs, b_de, b_lhs, b_lvs, b_lde} !== 6'b0) bad++;
        end
        chk("b_startup_idle", bad, 0);
    endtask

    initial begin
        int   bad, err, al_err, fs_extra, vs_low, hs_low, de_cnt;
        int   first_h, first_x, first_y, last_h, last_x, h, v;
        logic ex_de, prev_de, prev_hs, prev_vs, ex_hs, ex_vs;
        logic [10:0] ex_x, ex_y;

        a_rst_n = 1'b0; a_en = 1'b1;
        b_rst_n = 1'b0; b_en = 1'b1;
        err_req = 0; err_pan = 0; err_fc = 0;
        repeat (3) tick;

        // ---------------- reset state ----------------
        chk("a_rst_sync", 32'({a_lhs, a_lvs}), 32'd3);
        chk("a_rst_misc", 32'({a_de, a_lde, a_bl, a_fs}), 32'd0);
        chk("a_rst_xy",   32'({a_x, a_y}), 32'd0);
        chk("b_rst_idle", 32'({b_lhs, b_lvs, b_de, b_lde, b_bl, b_fs}), 32'd0);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("a_rst_fc", 32'(a_fc), 32'd0);
`endif

        // ---------------- dut_a startup ----------------
        a_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 999; i++) begin
            tick;
            if ({a_bl, a_fs, a_de, a_lde, a_lhs, a_lvs} !== 6'b000011) bad++;
        end
        chk("a_startup_idle", bad, 0);
        tick;   // 1000th edge: first RUN cycle, h=0 v=0
        chk("a_bl_rise",  32'(a_bl), 32'd1);
        chk("a_first_fs", 32'(a_fs), 32'd1);
        chk("a_lhs_lag",  32'(a_lhs), 32'd1);

        // ---------------- dut_a lines 0..35 ----------------
        prev_de = 1'b0; prev_hs = 1'b0; prev_vs = 1'b0;
        err = 0; al_err = 0; fs_extra = 0; vs_low = 0; hs_low = 0; de_cnt = 0;
        first_h = -1; first_x = -1; first_y = -1; last_h = -1; last_x = -1;
        for (int k = 1; k < 36 * 1056; k++) begin
            tick;
            h     = k % 1056;
            v     = k / 1056;
            ex_de = (h >= 216) && (h < 1016) && (v >= 35) && (v < 515);
            ex_x  = ex_de ? 11'(h - 216) : 11'd0;
            ex_y  = ex_de ? 11'(v - 35)  : 11'd0;
            ex_hs = (h < 128) ? 1'b0 : 1'b1;
            ex_vs = (v < 2)   ? 1'b0 : 1'b1;
            if ({a_de, a_x, a_y, a_bl} !== {ex_de, ex_x, ex_y, 1'b1}) err++;
            if (a_fs !== 1'b0) fs_extra++;
            if ({a_lde, a_lhs, a_lvs} !== {prev_de, prev_hs, prev_vs}) al_err++;
            if (a_lvs === 1'b0) vs_low++;
            if (v == 35) begin
                if (a_de === 1'b1) begin
                    de_cnt++;
                    if (first_h < 0) begin
                        first_h = h; first_x = int'(a_x); first_y = int'(a_y);
                    end
                    last_h = h; last_x = int'(a_x);
                end
                if (a_lhs === 1'b0) hs_low++;
            end
            prev_de = ex_de; prev_hs = ex_hs; prev_vs = ex_vs;
        end
        chk("a_req_err",   err, 0);
        chk("a_align1",    al_err, 0);
        chk("a_fs_extra",  fs_extra, 0);
        chk("a_vs_low",    vs_low, 2112);
        chk("a_hs_low",    hs_low, 128);
        chk("a_de_cnt",    de_cnt, 800);
        chk("a_first_h",   first_h, 216);
        chk("a_first_x",   first_x, 0);
        chk("a_first_y",   first_y, 0);
        chk("a_last_h",    last_h, 1015);
        chk("a_last_x",    last_x, 799);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("a_fc_one", 32'(a_fc), 32'd1);
`endif

        // ---------------- dut_b: startup, frames, HALT ----------------
        b_rst_n = 1'b1;
        startup_b;
        kb = 0; fs_prev = -1; fc_exp = 0;
        run_b(1);
        chk("b_first_fs", 32'(b_fs), 32'd1);
        chk("b_bl_rise",  32'(b_bl), 32'd1);
        run_b(424);              // up to frame 2, v=4, h=16
        b_en = 1'b0;             // dropped mid-frame: frame 2 must complete
        run_b(85);               // through k=509, last cycle of frame 2
        chk("b_run_err",   err_req, 0);
        chk("b_panel_err", err_pan, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if ({b_de, b_fs, b_x, b_y} !== 24'd0 || b_bl !== 1'b1) bad++;
            if (i >= 3 && {b_lhs, b_lvs, b_lde} !== 3'b000) bad++;
        end
        chk("b_halt", bad, 0);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("b_fc_hold", 32'(b_fc), 32'd3);
`endif

        // ---------------- resume ----------------
        b_en = 1'b1;
        kb = 0; fs_prev = -1;
        run_b(1);
        chk("b_resume_fs", 32'(b_fs), 32'd1);
        run_b(93);               // k=93: v=5 h=8, active
        chk("b_pre_rst_pix", 32'({b_de, b_x, b_y}), 32'({1'b1, 11'd1, 11'd1}));

        // ---------------- asynchronous reset mid-frame ----------------
        b_rst_n = 1'b0;
        #1;
        chk("b_async_rst", 32'({b_de, b_fs, b_bl, b_lhs, b_lvs, b_lde}), 32'd0);
        chk("b_async_xy",  32'({b_x, b_y}), 32'd0);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("b_async_fc", 32'(b_fc), 32'd0);
`endif
        tick;
        b_rst_n = 1'b1;
        startup_b;
        kb = 0; fs_prev = -1; fc_exp = 0;
        run_b(1);
        chk("b_restart_fs", 32'(b_fs), 32'd1);
        run_b(341);              // frame_starts at k=0,170,340
        chk("b_run_err2",   err_req, 0);
        chk("b_panel_err2", err_pan, 0);
        chk("b_fc_err",     err_fc, 0);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("b_fc_count", 32'(b_fc), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
